// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one 32-bit word at a time
// over a req/ack handshake, holds it for decode/execute, and picks the next PC
// from the decoder's resolved pc_src on retirement. One instruction in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc_next,
  input  logic        ir_ready,
  input  logic [1:0]  pc_src,
  input  logic [31:0] br_reg,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NEXT  = 2'b00;
  localparam logic [1:0] SRC_B_IMM = 2'b01;
  localparam logic [1:0] SRC_B_REG = 2'b10;
  localparam logic [1:0] SRC_X     = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] imm_ofs;
  logic        take_ack;
  logic        retire;
  logic        stray_ack;

  // Handshake events; ir_ready and imem_ack only count in their own state.
  assign take_ack  = (state == S_FETCH) && imem_ack;
  assign retire    = (state == S_HOLD) && ir_ready;
  assign stray_ack = (state != S_FETCH) && imem_ack;

  // Word offset of a relative branch: sign-extended imm16 scaled to bytes.
  assign imm_ofs = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Next-PC select; pc_src=X falls through to the sequential address.
  always_comb begin
    target = ir_pc_next;
    case (pc_src)
      SRC_NEXT:  target = ir_pc_next;
      SRC_B_IMM: target = ir_pc_next + imm_ofs;
      SRC_B_REG: target = {br_reg[31:2], 2'b00};
      SRC_X:     target = ir_pc_next;
      default:   target = ir_pc_next;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE is a single cycle after reset release.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem_ack) state_nxt = S_HOLD;
      S_HOLD:  if (ir_ready) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state so imem_req drops the instant reset asserts.
  always_comb begin
    imem_req  = (state == S_FETCH);
    ir_valid  = (state == S_HOLD);
    imem_addr = pc;
  end

  // PC advances only when the held instruction retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc <= RESET_VECTOR;
    else if (retire) pc <= target;
  end

  // Instruction capture; ir and its link value stay frozen through HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir         <= 32'h0;
      ir_pc_next <= 32'h0;
    end else if (take_ack) begin
      ir         <= imem_rdata;
      ir_pc_next <= pc + 32'd4;
    end
  end

  // Sticky fault: undefined pc_src retired, or ack with no request outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault <= 1'b0;
    else if ((retire && pc_src == SRC_X) || stray_ack)
      fault <= 1'b1;
  end

endmodule
